// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous RAM controller: FSM state encoding,
// default parameter values and the address range helper.
package mem_pkg;

  // Controller states. IDLE accepts requests, WAIT burns the extra access
  // cycles, RESP is the single acknowledge cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_WAIT_STATES = 1;

  // Wait counter width: enough for the largest legal WAIT_STATES (7).
  localparam int WCNT_W = 3;

  // True when any address bit at or above position aw is set, i.e. the
  // word address lies outside a 2**aw deep array.
  function automatic logic addr_out_of_range(input logic [31:0] a, input int aw);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ((i >= aw) && a[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Byte-enabled synchronous single-port word array with a registered read port.
// The storage itself is never reset; only the read register clears on clr so
// that the controller's read data comes up as zero.
module ram_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: only lanes whose byte enable is set are updated.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register: captures the addressed word on an enabled read, holds otherwise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_ram_ctrl.sv
// Request/acknowledge controller in front of a byte-enabled synchronous RAM,
// inserting WAIT_STATES extra cycles before each single-cycle response.
//
// Handshake: req (with we/addr/wdata/be) is sampled only while the controller
// is IDLE; the edge that sees req=1 in IDLE accepts the access and raises busy.
// Requests seen while busy are dropped, not queued. Completion is a one-cycle
// ack pulse WAIT_STATES+1 edges after acceptance, with err and (for reads)
// rdata valid alongside it; rdata then holds until the next read completes.
module sync_ram_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                busy,
  output logic                err,
  output mem_state_e          dbg_state_o
);

  localparam logic [WCNT_W-1:0] WS_LOAD = WCNT_W'(WAIT_STATES);
  localparam logic [WCNT_W-1:0] CNT_ONE = WCNT_W'(1);
  localparam bit                NO_WAIT = (WAIT_STATES == 0);

  mem_state_e            state_q;
  logic [WCNT_W-1:0]     cnt_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   be_q;
  logic                  ack_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  oor_rd_q;

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [DATA_W/8-1:0]   acc_be;
  logic                  acc_oor;
  logic                  enter_resp;
  logic                  ram_en;
  logic [DATA_W-1:0]     ram_rdata;

  // Operands of the access that commits on this edge. With no wait states the
  // commit happens on the accepting edge itself, so the live inputs are used
  // while IDLE; otherwise the latched copies are.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == ST_IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_be    = be;
    end
  end

  assign acc_oor    = addr_out_of_range(acc_addr, ADDR_W);
  assign enter_resp = ((state_q == ST_IDLE) && req && NO_WAIT) ||
                      ((state_q == ST_WAIT) && (cnt_q == CNT_ONE));
  // The array is touched only on the edge entering RESP, only in range, and
  // never while reset is held (an aborted access must not write).
  assign ram_en     = enter_resp && !acc_oor && !clr;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .clr     (clr),
    .en_i    (ram_en),
    .we_i    (acc_we),
    .be_i    (acc_be),
    .addr_i  (acc_addr[ADDR_W-1:0]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // Controller FSM with registered ack/busy/err and the out-of-range read flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      oor_rd_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            cnt_q   <= WS_LOAD;
            busy_q  <= 1'b1;
            state_q <= NO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        ack_q <= 1'b1;
        err_q <= acc_oor;
        // An out-of-range read must present zero until the next read.
        if (!acc_we) oor_rd_q <= acc_oor;
      end
    end
  end

  assign rdata       = oor_rd_q ? '0 : ram_rdata;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
